// File: rtl/serialin_target.sv
// Far end of the 3-wire panel link: receives the LSB-first display frame into a
// parallel latch and shifts the button word back on the return line.
module serialin_target #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             sdata,
    input  logic             sdata_pl,
    output logic             sdatain,
    input  logic [WIDTH-1:0] btin,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdata_sync_q;
    logic [SYNC_STAGES-1:0] pl_sync_q;
    logic                   sclk_dly_q;
    logic                   pl_dly_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   armed_q, armed_d;

    logic             sclk_s, sdata_s, pl_s;
    logic             sclk_rise, pl_rise, pl_fall, arm_ok;

    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             sdatain_q, sdatain_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic load_tx, start, shift_en, ovr_set, frame_end;

    // Input synchronizers; fill_q marks when the delay line holds real pin samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            pl_sync_q    <= '0;
            sclk_dly_q   <= 1'b0;
            pl_dly_q     <= 1'b0;
            fill_q       <= '0;
            armed_q      <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
            pl_sync_q    <= {pl_sync_q[SYNC_STAGES-2:0], sdata_pl};
            sclk_dly_q   <= sclk_s;
            pl_dly_q     <= pl_s;
            fill_q       <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            armed_q      <= armed_d;
        end
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign pl_s    = pl_sync_q[SYNC_STAGES-1];

    // A frame may only start once frame-enable has been seen low after reset,
    // so a frame that straddles reset release is never picked up halfway.
    assign arm_ok    = armed_q | (fill_q[SYNC_STAGES] & ~pl_dly_q);
    assign armed_d   = arm_ok;
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign pl_rise   = pl_s & ~pl_dly_q & arm_ok;
    assign pl_fall   = ~pl_s & pl_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pl_rise) state_d = SHIFT;
            SHIFT:   if (pl_fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_tx   = 1'b0;
        start     = 1'b0;
        shift_en  = 1'b0;
        ovr_set   = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                load_tx = 1'b1;
                start   = pl_rise;
            end
            SHIFT: begin
                shift_en  = sclk_rise & (cnt_q < CW'(WIDTH));
                ovr_set   = sclk_rise & (cnt_q == CW'(WIDTH));
                frame_end = pl_fall;
            end
            default: ;
        endcase
    end

    // Shift is resolved before frame end so a coincident last edge still counts.
    always_comb begin
        rx_d       = rx_q;
        tx_d       = tx_q;
        cnt_d      = cnt_q;
        ovr_d      = ovr_q;
        sdatain_d  = sdatain_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        if (load_tx) begin
            tx_d      = btin;
            sdatain_d = btin[0];
        end
        if (start) begin
            cnt_d = '0;
            ovr_d = 1'b0;
        end
        if (shift_en) begin
            rx_d      = {sdata_s, rx_q[WIDTH-1:1]};
            tx_d      = tx_q >> 1;
            sdatain_d = tx_q[1];
            cnt_d     = cnt_q + 1'b1;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
        if (frame_end) begin
            if ((cnt_d == CW'(WIDTH)) && !ovr_d) begin
                data_out_d = rx_d;
                valid_d    = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q       <= '0;
            tx_q       <= '0;
            cnt_q      <= '0;
            ovr_q      <= 1'b0;
            sdatain_q  <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            cnt_q      <= cnt_d;
            ovr_q      <= ovr_d;
            sdatain_q  <= sdatain_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign sdatain    = sdatain_q;
    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_serialin_target.sv
// Bench for serialin_target: a serializer driver, a frame-level expectation
// queue checked every cycle, and literal checks on latched and returned words.
module tb_serialin_target;

    localparam int W  = 8;
    localparam int HP = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sclk = 1'b0;
    logic         sdata = 1'b0;
    logic         sdata_pl = 1'b0;
    logic         sdatain;
    logic [W-1:0] btin = '0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         frame_err;

    serialin_target #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .sdata      (sdata),
        .sdata_pl   (sdata_pl),
        .sdatain    (sdatain),
        .btin       (btin),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_err;
        logic [W-1:0] data;
    } ev_t;

    ev_t          exp_q[$];
    logic [W-1:0] last_good = '0;
    int           n_vec = 0;
    int           n_err = 0;
    int           cnt_v = 0;
    int           cnt_e = 0;
    logic [15:0]  ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: pulses must match the queued frame outcomes, data_out the last good frame.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            chk("reset_outputs", {sdatain, data_valid, frame_err, data_out}, 0);
        end else begin
            if (data_valid && frame_err) chk("pulse_exclusive", 1, 0);
            if (data_valid || frame_err) begin
                if (data_valid) cnt_v++;
                if (frame_err)  cnt_e++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {data_valid, frame_err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", {30'd0, data_valid, frame_err}, e.is_err ? 2'b01 : 2'b10);
                    if (!e.is_err) last_good = e.data;
                end
            end
            chk("data_out", data_out, last_good);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sclk_pulse(input logic b);
        sdata = b;
        wait_clk(HP);
        sclk = 1'b1;
        wait_clk(HP);
        sclk = 1'b0;
    endtask

    // Serializer: bit 0 of the return word is read as pl rises, later bits after each falling sclk.
    task automatic send_frame(input logic [15:0] bits, input int n, output logic [15:0] r);
        ev_t e;
        r = '0;
        r[0] = sdatain;
        sdata_pl = 1'b1;
        wait_clk(HP);
        for (int i = 0; i < n; i++) begin
            sclk_pulse(bits[i]);
            r[i+1] = sdatain;
        end
        wait_clk(HP);
        e.is_err = (n != W);
        e.data   = bits[W-1:0];
        exp_q.push_back(e);
        sdata_pl = 1'b0;
        wait_clk(4 * HP);
        chk("frame_outcome_seen", exp_q.size(), 0);
    endtask

    initial begin
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(10);
        chk("post_reset_data_out", data_out, 0);

        // Test 1
        btin = 8'h3C;
        wait_clk(4);
        send_frame(16'h00A5, 8, ret);
        chk("t1_data_out", data_out, 8'hA5);
        chk("t1_return", ret[7:0], 8'h3C);
        chk("t1_valid_count", cnt_v, 1);

        // Test 3: short frame then good one
        send_frame(16'h0015, 5, ret);
        chk("t3_short_keep", data_out, 8'hA5);
        chk("t3_err_count", cnt_e, 1);
        send_frame(16'h005A, 8, ret);
        chk("t3_next_ok", data_out, 8'h5A);

        // Test 2: back-to-back, btin changed between frames
        btin = 8'hFF;
        wait_clk(4);
        send_frame(16'h0001, 8, ret);
        chk("t2_first", data_out, 8'h01);
        chk("t2_ret_first", ret[7:0], 8'hFF);
        btin = 8'h00;
        wait_clk(4);
        send_frame(16'h0080, 8, ret);
        chk("t2_second", data_out, 8'h80);
        chk("t2_ret_second", ret[7:0], 8'h00);

        // Test 4: overlong frame; zeros shift into the return register past bit 7
        btin = 8'hFF;
        wait_clk(4);
        send_frame(16'h01C3, 9, ret);
        chk("t4_keep", data_out, 8'h80);
        chk("t4_ret_bits", ret[7:0], 8'hFF);
        chk("t4_ret_after8", ret[8], 1'b0);
        chk("t4_ret_held", ret[9], 1'b0);
        chk("t4_err_count", cnt_e, 2);

        // Test 5: reset mid-frame, release while pl still high
        sdata_pl = 1'b1;
        wait_clk(HP);
        for (int i = 0; i < 3; i++) sclk_pulse(1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        last_good = '0;
        wait_clk(3);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) sclk_pulse(1'b0);
        wait_clk(HP);
        sdata_pl = 1'b0;
        wait_clk(4 * HP);
        chk("t5_no_pulse_data", data_out, 0);
        chk("t5_counts", {cnt_v[15:0], cnt_e[15:0]}, {16'd4, 16'd2});
        send_frame(16'h0077, 8, ret);
        chk("t5_next_ok", data_out, 8'h77);

        // Test 6: sclk with pl low, then empty pl pulse
        for (int i = 0; i < 4; i++) sclk_pulse(i[0]);
        wait_clk(4 * HP);
        chk("t6_idle_counts", {cnt_v[15:0], cnt_e[15:0]}, {16'd5, 16'd2});
        send_frame(16'h0000, 0, ret);
        chk("t6_empty_err", cnt_e, 3);
        chk("t6_keep", data_out, 8'h77);
        chk("final_valid_count", cnt_v, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
